// File: rtl/result_buf_wr.sv
// result_buf_wr: packs 4-bit class results eight per 32-bit word and writes them to the result buffer
module result_buf_wr #(
    parameter int IN_IMG_NUM = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              res_valid_i,
    input  logic [3:0]        res_class_i,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [31:0]       buf_wdata_o,
    output logic              busy_o,
    output logic              buf_wr_done
);
    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;
    state_t state, state_nxt;
    logic [7:0] img_cnt;
    logic [31:0] pack;
    logic [31:0] pack_nxt;
    logic [ADDR_W-1:0] addr;
    logic accept;
    logic last_img;
    logic word_end;
    assign accept = state == COLLECT && res_valid_i;
    assign last_img = img_cnt == 8'(IN_IMG_NUM - 1);
    assign word_end = img_cnt[2:0] == 3'd7 || last_img;
    assign pack_nxt = pack | (32'(res_class_i) << {img_cnt[2:0], 2'b00});
    // state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else state <= state_nxt;
    end
    // next-state: the last accepted image ends collection; FLUSH and DONE last one cycle each
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = COLLECT;
            COLLECT: if (accept && last_img) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // packing datapath and registered outputs; a completed word is written the cycle after its last nibble
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            img_cnt     <= '0;
            pack        <= '0;
            addr        <= '0;
            buf_we_o    <= 1'b0;
            buf_addr_o  <= '0;
            buf_wdata_o <= '0;
            busy_o      <= 1'b0;
            buf_wr_done <= 1'b0;
        end else begin
            buf_we_o    <= 1'b0;
            buf_wr_done <= state == FLUSH;
            busy_o      <= state_nxt != IDLE;
            if (state == IDLE && start_i) begin
                img_cnt <= '0;
                pack    <= '0;
                addr    <= '0;
            end else if (accept) begin
                img_cnt <= img_cnt + 8'd1;
                if (word_end) begin
                    buf_we_o    <= 1'b1;
                    buf_wdata_o <= pack_nxt;
                    buf_addr_o  <= addr;
                    addr        <= addr + ADDR_W'(1);
                    pack        <= '0;
                end else begin
                    pack <= pack_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_result_buf_wr.sv
// tb_result_buf_wr: randomized runs against a word-packing scoreboard, default and 8-image instances
module tb_result_buf_wr;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic s_start = 1'b0;
    logic s_valid = 1'b0;
    logic [3:0] s_class = 4'd0;
    logic sel = 1'b0;
    logic we_a, we_b, busy_a, busy_b, done_a, done_b;
    logic [3:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic m_we, m_busy, m_done;
    logic [3:0] m_addr;
    logic [31:0] m_data;
    int cyc = 0;
    int errs = 0;
    int checks = 0;
    int w_cyc[$];
    int w_addr[$];
    logic [31:0] w_data[$];
    int d_cyc[$];
    logic busy_h [int];
    logic [3:0] cls [0:255];
    int vt [0:255];

    result_buf_wr dut_a (
        .clk_i(clk), .rstn_i(rstn), .start_i(s_start & ~sel), .res_valid_i(s_valid & ~sel),
        .res_class_i(s_class), .buf_we_o(we_a), .buf_addr_o(addr_a), .buf_wdata_o(data_a),
        .busy_o(busy_a), .buf_wr_done(done_a)
    );
    result_buf_wr #(.IN_IMG_NUM(8), .ADDR_W(4)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .start_i(s_start & sel), .res_valid_i(s_valid & sel),
        .res_class_i(s_class), .buf_we_o(we_b), .buf_addr_o(addr_b), .buf_wdata_o(data_b),
        .busy_o(busy_b), .buf_wr_done(done_b)
    );

    assign m_we   = sel ? we_b : we_a;
    assign m_addr = sel ? addr_b : addr_a;
    assign m_data = sel ? data_b : data_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // record every write, done pulse and busy level of the selected instance, sampled mid-cycle
    always @(negedge clk) begin
        if (m_we) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(int'(m_addr));
            w_data.push_back(m_data);
        end
        if (m_done) d_cyc.push_back(cyc);
        busy_h[cyc] = m_busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        w_cyc.delete();
        w_addr.delete();
        w_data.delete();
        d_cyc.delete();
    endtask

    // one run of n images; call at posedge+1. inject adds ignored start/valid pulses.
    task automatic run(input string tag, input int n, input int gmin, input int gmax,
                       input bit inject, input bit preset);
        int ts, last, nw, k, bad;
        logic [31:0] d;
        clear_log();
        if (inject) begin
            s_valid = 1'b1;
            s_class = 4'h5;
            @(posedge clk) #1;
            s_valid = 1'b0;
        end
        s_start = 1'b1;
        ts = cyc + 1;
        @(posedge clk) #1;
        s_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(gmin, gmax);
            for (int j = 0; j < g; j++) begin
                s_valid = 1'b0;
                s_start = inject && $urandom_range(0, 1) == 1;
                @(posedge clk) #1;
            end
            if (!preset) cls[i] = 4'($urandom_range(0, 9));
            s_start = inject && $urandom_range(0, 1) == 1;
            s_valid = 1'b1;
            s_class = cls[i];
            vt[i] = cyc + 1;
            @(posedge clk) #1;
        end
        s_start = 1'b0;
        s_valid = inject;
        s_class = 4'($urandom_range(0, 15));
        repeat (2) @(posedge clk) #1;
        s_valid = 1'b0;
        repeat (4) @(posedge clk) #1;
        last = vt[n-1];
        nw = (n + 7) / 8;
        chk({tag, ".nwr"}, w_cyc.size(), nw);
        for (int w = 0; w < nw && w < w_cyc.size(); w++) begin
            k = (8 * w + 7 < n - 1) ? 8 * w + 7 : n - 1;
            d = 0;
            for (int i = 8 * w; i <= k; i++) d |= 32'(cls[i]) << (4 * (i - 8 * w));
            chk({tag, ".wcyc"}, w_cyc[w], vt[k]);
            chk({tag, ".waddr"}, w_addr[w], w);
            chk({tag, ".wdata"}, w_data[w], d);
        end
        chk({tag, ".ndone"}, d_cyc.size(), 1);
        if (d_cyc.size() > 0) chk({tag, ".dcyc"}, d_cyc[0], last + 1);
        bad = 0;
        for (int c = ts - 1; c <= last + 3; c++)
            if (busy_h.exists(c) && busy_h[c] !== (c >= ts && c <= last + 1)) bad++;
        chk({tag, ".busy"}, bad, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.a", {we_a, busy_a, done_a, addr_a, data_a}, '0);
        chk("rst.b", {we_b, busy_b, done_b, addr_b, data_b}, '0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) cls[i] = 4'((i + 1) % 10);
        run("b2b", 10, 0, 0, 0, 1);
        if (w_data.size() == 2) begin
            chk("b2b.w0lit", w_data[0], 32'h87654321);
            chk("b2b.w1lit", w_data[1], 32'h00000009);
        end
        run("gaps", 10, 1, 3, 0, 0);
        run("inject", 10, 0, 2, 1, 0);
        clear_log();
        s_start = 1'b1;
        @(posedge clk) #1;
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_class = 4'($urandom_range(0, 9));
            @(posedge clk) #1;
        end
        s_valid = 1'b0;
        chk("mid.busy_pre", busy_a, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid.outs", {we_a, busy_a, done_a, addr_a, data_a}, '0);
        @(posedge clk) #1;
        @(posedge clk) #1;
        rstn = 1'b1;
        chk("mid.nodone", d_cyc.size(), 0);
        run("after_rst", 10, 0, 1, 0, 0);
        run("rep1", 10, 0, 0, 0, 1);
        run("rep2", 10, 0, 0, 0, 1);
        for (int r = 0; r < 4; r++) run("rand", 10, 0, 2, r[0], 0);
        sel = 1'b1;
        @(posedge clk) #1;
        for (int i = 0; i < 8; i++) cls[i] = 4'(7 - i);
        run("n8", 8, 0, 0, 0, 1);
        if (w_data.size() == 1) chk("n8.lit", w_data[0], 32'h01234567);
        run("n8rand", 8, 0, 2, 1, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/result_buf_wr.md
RESULT_BUF_WR -- requirements
Module: result_buf_wr

Interface
REQ-001 SHALL have parameter IN_IMG_NUM, default 10, number of image results per run (1..255).
REQ-002 SHALL have parameter ADDR_W, default 4, result-buffer word-address width; ceil(IN_IMG_NUM/8) <= 2^ADDR_W.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  single-cycle run-start pulse, already edge-detected upstream.
REQ-006 SHALL have port res_valid_i  input  1  classification result valid, one result per high cycle.
REQ-007 SHALL have port res_class_i  input  4  class index 0..9 qualified by res_valid_i.
REQ-008 SHALL have port buf_we_o  output  1  result-buffer write strobe, one cycle per word.
REQ-009 SHALL have port buf_addr_o  output  ADDR_W  result-buffer word address.
REQ-010 SHALL have port buf_wdata_o  output  32  packed result word.
REQ-011 SHALL have port busy_o  output  1  run in progress.
REQ-012 SHALL have port buf_wr_done  output  1  single-cycle pulse: all results written.

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, FLUSH, DONE; all outputs registered.
REQ-014 IDLE: start_i=1 -> COLLECT next cycle; image counter, nibble index, pack register, word address cleared to 0.
REQ-015 SHALL ignore start_i in any state other than IDLE.
REQ-016 SHALL ignore res_valid_i in IDLE, FLUSH, DONE (no counter change, no write).
REQ-017 COLLECT, res_valid_i=1: res_class_i placed in bits [4k+3:4k] of the pack word, k = image index mod 8; image counter +1.
REQ-018 When accepted result is nibble 7 or the last image (index IN_IMG_NUM-1): next cycle buf_we_o=1, buf_wdata_o = completed word (unfilled upper nibbles 0), buf_addr_o = current word address.
REQ-019 After each write, word address SHALL increment by 1 and pack register clear to 0 in the same edge as the write is issued.
REQ-020 A res_valid_i in the cycle buf_we_o is high SHALL be accepted into the fresh word at nibble 0 (back-to-back results, no stall).
REQ-021 Accepting the last image SHALL move COLLECT -> FLUSH; FLUSH is the cycle buf_we_o is high for the final word; FLUSH -> DONE unconditionally.
REQ-022 DONE: buf_wr_done=1 for exactly that one cycle; DONE -> IDLE unconditionally.
REQ-023 Latency: final res_valid_i at cycle T -> final buf_we_o at T+1 -> buf_wr_done at T+2.
REQ-024 busy_o SHALL be 1 in COLLECT, FLUSH, DONE and 0 in IDLE.
REQ-025 buf_we_o SHALL be 0 in all cycles other than those in REQ-018; buf_wdata_o/buf_addr_o hold last written values between strobes.
REQ-026 Image counter width SHALL be 8 bits; word address wraps modulo 2^ADDR_W (not reachable under REQ-002).
REQ-027 Total writes per run SHALL equal ceil(IN_IMG_NUM/8); IN_IMG_NUM=8 -> one write, in FLUSH, no duplicate.

Reset
REQ-028 rstn_i low SHALL asynchronously force state IDLE and all outputs, counters, pack register, word address to 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no buf_wr_done; the next start_i after release begins a clean run at address 0.
REQ-030 First rising edge after rstn_i deassertion SHALL be a normal IDLE cycle.

Verification
REQ-031 Defaults; start_i, then 10 back-to-back results 1..9,0 -> write addr0 data 0x87654321, write addr1 data 0x00000009, buf_wr_done 2 cycles after 10th valid.
REQ-032 Results with 1-3 idle cycles between valids, classes all 0xF-masked values 0..9 -> same packing, exactly 2 writes, one buf_wr_done pulse, busy_o high start+1 through DONE.
REQ-033 start_i pulsed during COLLECT and res_valid_i pulsed in IDLE/DONE -> no restart, no counter change, no extra writes.
REQ-034 rstn_i low after 5 results -> all outputs 0 immediately; new run of 10 results -> writes at addr0, addr1 only, one buf_wr_done.
REQ-035 IN_IMG_NUM=8, results 7,6,5,4,3,2,1,0 -> single write addr0 data 0x01234567, buf_wr_done next cycle.
REQ-036 Two consecutive runs -> second run restarts at address 0 with identical timing.
